// File: rtl/psk_modulator_pkg.sv
// Shared types and the sine-table fill function for the PSK carrier modulator.
package psk_pkg;

    typedef enum logic {
        MODE_BPSK = 1'b0,
        MODE_QPSK = 1'b1
    } mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam real PI = 3.14159265358979323846;

    // One carrier-period sine entry, scaled to full signed range and truncated toward zero.
    function automatic int rom_fill(input int k, input int lut_aw, input int data_w);
        real amp;
        real ang;
        amp = (2.0 ** (data_w - 1)) - 1.0;
        ang = 2.0 * PI * real'(k) / (2.0 ** lut_aw);
        return $rtoi($sin(ang) * amp);
    endfunction

endpackage

// File: rtl/psk_modulator_if.sv
// Symbol-in / sample-out bundle of the PSK modulator.
interface psk_modulator_if #(
    parameter int DATA_W = 16
);
    logic                     mode;
    logic                     sym_valid;
    logic [1:0]               sym_data;
    logic                     sym_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_sample;
    logic                     underrun;

    modport master (
        output mode, sym_valid, sym_data,
        input  sym_ready, out_valid, out_sample, underrun
    );

    modport slave (
        input  mode, sym_valid, sym_data,
        output sym_ready, out_valid, out_sample, underrun
    );
endinterface

// File: rtl/psk_modulator_sine_rom.sv
// Full-period sine table with a sine port at p and a cosine port at p + DEPTH/4.
module psk_sine_rom
    import psk_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LUT_AW = 8
) (
    input  logic [LUT_AW-1:0]        phase,
    output logic signed [DATA_W-1:0] sin_val,
    output logic signed [DATA_W-1:0] cos_val
);
    localparam int DEPTH = 2 ** LUT_AW;

    logic signed [DATA_W-1:0] rom_s [DEPTH];
    logic [LUT_AW-1:0]        cos_addr_s;

    // Each entry is a constant expression, so the table folds to a ROM.
    for (genvar k = 0; k < DEPTH; k++) begin : g_fill
        assign rom_s[k] = DATA_W'(rom_fill(k, LUT_AW, DATA_W));
    end

    // The quarter-period offset wraps naturally at LUT_AW bits.
    assign cos_addr_s = phase + LUT_AW'(DEPTH / 4);
    assign sin_val    = rom_s[phase];
    assign cos_val    = rom_s[cos_addr_s];

endmodule

// File: rtl/psk_modulator.sv
// BPSK/QPSK carrier modulator: one symbol in, SPS phase-continuous samples out.
module psk_modulator
    import psk_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LUT_AW    = 8,
    parameter int SPS       = 256,
    parameter int PHASE_INC = 1
) (
    input logic            clk,
    input logic            reset,
    psk_modulator_if.slave bus
);
    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

    state_t                   state_r;
    logic [LUT_AW-1:0]        phase_r;
    logic [CNT_W-1:0]         cnt_r;
    logic [1:0]               sym_r;
    mode_t                    mode_r;
    logic                     out_valid_r;
    logic signed [DATA_W-1:0] out_sample_r;
    logic                     underrun_r;

    logic                     last_s;
    logic                     sym_ready_s;
    logic                     accept_s;
    logic signed [DATA_W-1:0] sin_s;
    logic signed [DATA_W-1:0] cos_s;
    logic signed [DATA_W:0]   sin_x_s;
    logic signed [DATA_W:0]   cos_x_s;
    logic signed [DATA_W:0]   s_term_s;
    logic signed [DATA_W:0]   c_term_s;
    logic signed [DATA_W:0]   sum_s;
    logic signed [DATA_W:0]   half_s;
    logic signed [DATA_W-1:0] sample_s;

    psk_sine_rom #(
        .DATA_W (DATA_W),
        .LUT_AW (LUT_AW)
    ) u_rom (
        .phase   (phase_r),
        .sin_val (sin_s),
        .cos_val (cos_s)
    );

    // Ready depends only on state and position in the symbol, never on sym_valid.
    always_comb begin
        last_s      = (cnt_r == CNT_W'(SPS - 1));
        sym_ready_s = (state_r == S_IDLE) || ((state_r == S_RUN) && last_s);
        accept_s    = bus.sym_valid && sym_ready_s;
    end

    // Sign selection and QPSK half-sum at one extra bit so the sum cannot wrap.
    always_comb begin
        sin_x_s  = {sin_s[DATA_W-1], sin_s};
        cos_x_s  = {cos_s[DATA_W-1], cos_s};
        s_term_s = sym_r[0] ? sin_x_s : -sin_x_s;
        c_term_s = sym_r[1] ? cos_x_s : -cos_x_s;
        sum_s    = c_term_s + s_term_s;
        half_s   = sum_s >>> 1'd1;
        case (mode_r)
            MODE_BPSK: sample_s = s_term_s[DATA_W-1:0];
            MODE_QPSK: sample_s = half_s[DATA_W-1:0];
            default:   sample_s = '0;
        endcase
    end

    // Control FSM, phase/sample counters, symbol latch and registered output stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_IDLE;
            phase_r      <= '0;
            cnt_r        <= '0;
            sym_r        <= 2'b00;
            mode_r       <= MODE_BPSK;
            out_valid_r  <= 1'b0;
            out_sample_r <= '0;
            underrun_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    out_valid_r  <= 1'b0;
                    out_sample_r <= '0;
                    // Output still valid here means the last burst just starved.
                    underrun_r   <= out_valid_r;
                    phase_r      <= '0;
                    cnt_r        <= '0;
                    if (accept_s) begin
                        state_r <= S_RUN;
                        sym_r   <= bus.sym_data;
                        mode_r  <= mode_t'(bus.mode);
                    end
                end
                S_RUN: begin
                    out_valid_r  <= 1'b1;
                    out_sample_r <= sample_s;
                    underrun_r   <= 1'b0;
                    phase_r      <= phase_r + LUT_AW'(PHASE_INC);
                    if (last_s) begin
                        cnt_r <= '0;
                        if (accept_s) begin
                            // Phase keeps running so the symbol boundary is continuous.
                            sym_r  <= bus.sym_data;
                            mode_r <= mode_t'(bus.mode);
                        end else begin
                            state_r <= S_IDLE;
                            phase_r <= '0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r      <= S_IDLE;
                    phase_r      <= '0;
                    cnt_r        <= '0;
                    out_valid_r  <= 1'b0;
                    out_sample_r <= '0;
                    underrun_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sym_ready  = sym_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_sample = out_sample_r;
    assign bus.underrun   = underrun_r;

endmodule

// File: tb/tb_psk_modulator.sv
// Scoreboard bench for psk_modulator: default build plus an SPS=64, PHASE_INC=4 build.
module tb_psk_modulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_v;
    logic       valid_v;
    logic [1:0] data_v;
    bit         sel;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int cap[1024];

    always #5 clk = ~clk;

    psk_modulator_if #(.DATA_W(16)) ia ();
    psk_modulator_if #(.DATA_W(16)) ib ();

    assign ia.mode      = mode_v;
    assign ia.sym_data  = data_v;
    assign ia.sym_valid = valid_v & ~sel;
    assign ib.mode      = mode_v;
    assign ib.sym_data  = data_v;
    assign ib.sym_valid = valid_v & sel;

    psk_modulator #(.DATA_W(16), .LUT_AW(8), .SPS(256), .PHASE_INC(1)) dut_a (
        .clk(clk), .reset(rst), .bus(ia));
    psk_modulator #(.DATA_W(16), .LUT_AW(8), .SPS(64), .PHASE_INC(4)) dut_b (
        .clk(clk), .reset(rst), .bus(ib));

    wire               rdy = sel ? ib.sym_ready : ia.sym_ready;
    wire               ov  = sel ? ib.out_valid : ia.out_valid;
    wire               ur  = sel ? ib.underrun  : ia.underrun;
    wire signed [15:0] os  = sel ? ib.out_sample : ia.out_sample;

    // Reference sample from the real-valued carrier at phase ph of a 256-entry period.
    function automatic int model(input int ph, input logic [1:0] sym, input logic md);
        real pi;
        int s, c, st, ct;
        pi = 3.14159265358979323846;
        s  = $rtoi($sin(2.0 * pi * ph / 256.0) * 32767.0);
        c  = $rtoi($sin(2.0 * pi * ((ph + 64) % 256) / 256.0) * 32767.0);
        st = sym[0] ? s : -s;
        ct = sym[1] ? c : -c;
        if (md) return (ct + st) >>> 1;
        return st;
    endfunction

    // Drive n back-to-back symbols from idle, then starve; check every cycle against the scoreboard.
    task automatic run_burst(input string name, input bit use_b, input int n,
                             input logic [1:0] sa, input logic [1:0] sb, input logic md);
        int sps, inc, acc_cyc, first_v, last_v, nvalid, und, und_cyc, idx, e;
        bit pend, er;
        sps = use_b ? 64 : 256;
        inc = use_b ? 4 : 1;
        sel = use_b;
        exp_q.delete();
        for (int j = 0; j < n; j++)
            for (int k = 0; k < sps; k++)
                exp_q.push_back(model(((j * sps + k) * inc) % 256, (j == 0) ? sa : sb, md));
        acc_cyc = -1; first_v = -1; last_v = -1; nvalid = 0; und = 0; und_cyc = -1; idx = 0;
        data_v = sa; mode_v = md; valid_v = 1'b1;
        for (int cyc = 0; cyc < n * sps + 8; cyc++) begin
            pend = valid_v && (rdy === 1'b1);
            @(posedge clk); #1;
            if (pend) begin
                if (idx == 0) acc_cyc = cyc;
                idx++;
                if (idx < n) data_v = sb;
                else valid_v = 1'b0;
            end
            if (acc_cyc >= 0) begin
                er = (cyc - acc_cyc >= n * sps) ? 1'b1 : ((cyc - acc_cyc) % sps == sps - 1);
                checks++;
                if (rdy !== er) begin
                    errors++;
                    $display("FAIL %s sym_ready cyc=%0d got=%b expected=%b", name, cyc, rdy, er);
                end
            end
            if (ov === 1'b1) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                nvalid++;
                if (nvalid <= 1024) cap[nvalid-1] = int'(os);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_sample cyc=%0d got=%0d expected=none", name, cyc, os);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(os) !== e) begin
                        errors++;
                        $display("FAIL %s sample %0d got=%0d expected=%0d", name, nvalid - 1, os, e);
                    end
                end
            end else begin
                checks++;
                if (os !== 16'sd0) begin
                    errors++;
                    $display("FAIL %s idle_sample cyc=%0d got=%0d expected=0", name, cyc, os);
                end
            end
            if (ur === 1'b1) begin
                und++;
                und_cyc = cyc;
            end
        end
        valid_v = 1'b0;
        checks++;
        if (acc_cyc < 0 || first_v !== acc_cyc + 1) begin
            errors++;
            $display("FAIL %s latency got_first_valid=%0d expected=%0d", name, first_v, acc_cyc + 1);
        end
        checks++;
        if (nvalid !== n * sps || last_v - first_v + 1 !== n * sps) begin
            errors++;
            $display("FAIL %s valid_run got=%0d span=%0d expected=%0d", name, nvalid, last_v - first_v + 1, n * sps);
        end
        checks++;
        if (und !== 1 || und_cyc !== last_v + 1) begin
            errors++;
            $display("FAIL %s underrun got_count=%0d at=%0d expected=1 at=%0d", name, und, und_cyc, last_v + 1);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s missing_samples got=%0d expected=0", name, exp_q.size());
        end
    endtask

    task automatic spot(input string name, input int idx, input int expv);
        checks++;
        if (cap[idx] !== expv) begin
            errors++;
            $display("FAIL %s cap[%0d] got=%0d expected=%0d", name, idx, cap[idx], expv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_v = 1'b0; data_v = 2'b00; mode_v = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ia.out_valid !== 1'b0 || ia.out_sample !== 16'sd0 || ia.underrun !== 1'b0 || ia.sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_a got=%b/%0d/%b/%b expected=0/0/0/1", ia.out_valid, ia.out_sample, ia.underrun, ia.sym_ready);
        end
        checks++;
        if (ib.out_valid !== 1'b0 || ib.out_sample !== 16'sd0 || ib.underrun !== 1'b0 || ib.sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_b got=%b/%0d/%b/%b expected=0/0/0/1", ib.out_valid, ib.out_sample, ib.underrun, ib.sym_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_bpsk_single();
        run_burst("bpsk_single", 1'b0, 1, 2'b01, 2'b01, 1'b0);
        spot("bpsk_single", 0, 0);
        spot("bpsk_single", 64, 32767);
        spot("bpsk_single", 128, 0);
        spot("bpsk_single", 192, -32767);
    endtask

    task automatic test_back_to_back();
        run_burst("bpsk_b2b", 1'b0, 2, 2'b01, 2'b00, 1'b0);
        spot("bpsk_b2b", 256, 0);
        spot("bpsk_b2b", 320, -32767);
    endtask

    task automatic test_qpsk();
        run_burst("qpsk", 1'b0, 2, 2'b11, 2'b00, 1'b1);
        spot("qpsk", 0, 16383);
        spot("qpsk", 256, -16384);
    endtask

    task automatic test_restart();
        run_burst("restart", 1'b0, 1, 2'b00, 2'b00, 1'b0);
        spot("restart", 0, 0);
        spot("restart", 64, -32767);
    endtask

    task automatic test_inc4();
        run_burst("inc4", 1'b1, 2, 2'b01, 2'b00, 1'b0);
        spot("inc4", 16, 32767);
        spot("inc4", 64, 0);
        spot("inc4", 80, -32767);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen, bad;
        sel = 1'b0; data_v = 2'b01; mode_v = 1'b0; valid_v = 1'b1; seen = 0;
        for (int cyc = 0; cyc < 400 && seen < 100; cyc++) begin
            @(posedge clk); #1;
            valid_v = 1'b0;
            if (ia.out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 100) begin
            errors++;
            $display("FAIL reset_mid reach_sample got=%0d expected=100", seen);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ia.out_valid !== 1'b0 || ia.out_sample !== 16'sd0 || ia.sym_ready !== 1'b1 || ia.underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid outputs got=%b/%0d/%b/%b expected=0/0/1/0", ia.out_valid, ia.out_sample, ia.sym_ready, ia.underrun);
        end
        rst = 1'b0;
        bad = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk); #1;
            if (ia.underrun !== 1'b0 || ia.out_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL reset_mid quiet got=%0d expected=0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_bpsk_single();
        test_back_to_back();
        test_qpsk();
        test_restart();
        test_inc4();
        test_reset_mid();
        test_restart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
